// File: rtl/ppu_timing.sv
// ppu_timing: NTSC dot/scanline raster counter with odd-frame skip, pixel/frame strobes, VBlank flag and NMI.
module ppu_timing #(
  parameter int DOTS     = 341,
  parameter int LINES    = 262,
  parameter int VIS_W    = 256,
  parameter int VIS_H    = 240,
  parameter int VBL_LINE = 241
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rendering_en,
  input  logic       nmi_en,
  input  logic       status_rd,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic       pixel_en,
  output logic       frame,
  output logic       odd_frame,
  output logic       vbl_flag,
  output logic       nmi
);
  localparam logic [8:0] LAST_DOT  = 9'(DOTS - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS - 2);
  localparam logic [8:0] LAST_LINE = 9'(LINES - 1);
  localparam logic [8:0] VBL       = 9'(VBL_LINE);
  localparam logic [8:0] W         = 9'(VIS_W);
  localparam logic [8:0] H         = 9'(VIS_H);

  logic suppress;
  logic pre_line, end_of_line, wrap;

  assign pre_line    = scanline == LAST_LINE;
  assign end_of_line = dot == LAST_DOT;
  // The odd-frame skip jumps straight from the second-to-last pre-render dot to (0,0).
  assign wrap        = pre_line && (end_of_line || (dot == SKIP_DOT && odd_frame && rendering_en));

  assign pixel_en = scanline < H && dot >= 9'd1 && dot <= W;
  assign frame    = pre_line;
  assign nmi      = vbl_flag & nmi_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot       <= '0;
      scanline  <= '0;
      odd_frame <= 1'b0;
    end else if (wrap) begin
      dot       <= '0;
      scanline  <= '0;
      odd_frame <= ~odd_frame;
    end else if (end_of_line) begin
      dot      <= '0;
      scanline <= scanline + 9'd1;
    end else begin
      dot <= dot + 9'd1;
    end
  end

  // Clear beats a $2002 read, which beats the set; a read one dot early suppresses the set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbl_flag <= 1'b0;
      suppress <= 1'b0;
    end else if (pre_line && dot == 9'd1) begin
      vbl_flag <= 1'b0;
      suppress <= 1'b0;
    end else if (status_rd) begin
      vbl_flag <= 1'b0;
      if (scanline == VBL && dot == 9'd0) suppress <= 1'b1;
    end else if (scanline == VBL && dot == 9'd1 && !suppress) begin
      vbl_flag <= 1'b1;
    end
  end
endmodule
